onchip_mem_loader: RTL and testbench

ONCHIP_MEM_LOADER -- requirements
Module: onchip_mem_loader

---
 rtl/onchip_mem_loader_pkg.sv | 20 ++
 rtl/onchip_mem_loader_timeout.sv | 32 +++
 rtl/onchip_mem_loader.sv | 191 +++++++++++++++++++
 tb/tb_onchip_mem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_loader_pkg.sv
// rtl/onchip_mem_loader_pkg.sv - shared types and constants for the on-chip memory loader
package onchip_mem_loader_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM
    } state_t;

endpackage

// File: rtl/onchip_mem_loader_timeout.sv
// rtl/onchip_mem_loader_timeout.sv - inter-byte idle watchdog for an open frame
module onchip_mem_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // The idle cycle that would bring the count to TIMEOUT_CYCLES is the
    // expiry cycle, unless a byte arrives in it; a byte always wins.
    assign expired = enable & ~clear & (count == LAST);

    // Count idle cycles inside a frame; any accepted byte restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || expired || !enable) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/onchip_mem_loader.sv
// rtl/onchip_mem_loader.sv - byte-stream frame loader writing 32-bit words into on-chip RAM
module onchip_mem_loader
    import onchip_mem_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    output logic        cpu_reset_req,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  err_code
);

    state_t state;
    state_t state_nxt;

    logic        accept;
    logic        expired;
    logic        sync_hit;
    logic        wr_fire;
    logic        frame_end;
    logic        csum_bad;

    logic [7:0]  addr_hi;
    logic [7:0]  cnt_hi;
    logic [15:0] wr_addr;
    logic [15:0] words_left;
    logic [1:0]  lane;
    logic [23:0] word_buf;
    logic [7:0]  csum;
    logic [7:0]  csum_final;

    assign accept         = in_valid & in_ready;
    assign csum_final     = csum + in_data;
    assign mem_byteenable = 4'hF;
    assign load_busy      = (state != S_IDLE) | load_done;
    assign cpu_reset_req  = load_busy;

    onchip_mem_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (state != S_IDLE),
        .expired (expired)
    );

    // Frame parser state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus single-cycle event strobes derived from the accepted byte.
    always_comb begin
        state_nxt = state;
        sync_hit  = 1'b0;
        wr_fire   = 1'b0;
        frame_end = 1'b0;
        csum_bad  = 1'b0;
        if (expired) begin
            state_nxt = S_IDLE;
        end else if (accept) begin
            unique case (state)
                S_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_nxt = S_ADDR_HI;
                        sync_hit  = 1'b1;
                    end
                end
                S_ADDR_HI: state_nxt = S_ADDR_LO;
                S_ADDR_LO: state_nxt = S_CNT_HI;
                S_CNT_HI:  state_nxt = S_CNT_LO;
                S_CNT_LO: begin
                    state_nxt = ({cnt_hi, in_data} == 16'h0000) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    if (lane == 2'd3) begin
                        wr_fire = 1'b1;
                        if (words_left == 16'd1) begin
                            state_nxt = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    state_nxt = S_IDLE;
                    frame_end = 1'b1;
                    csum_bad  = (csum_final != 8'h00);
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Handshake and registered RAM strobes; the block never backpressures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready       <= 1'b0;
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;
            load_done      <= 1'b0;
        end else begin
            in_ready       <= 1'b1;
            mem_write      <= wr_fire;
            mem_chipselect <= wr_fire;
            load_done      <= frame_end | expired;
        end
    end

    // Header capture, little-endian word packing and write address stepping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_hi       <= '0;
            cnt_hi        <= '0;
            wr_addr       <= '0;
            words_left    <= '0;
            lane          <= '0;
            word_buf      <= '0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else if (accept && !expired) begin
            unique case (state)
                S_ADDR_HI: addr_hi <= in_data;
                S_ADDR_LO: wr_addr <= {addr_hi, in_data};
                S_CNT_HI:  cnt_hi  <= in_data;
                S_CNT_LO: begin
                    words_left <= {cnt_hi, in_data};
                    lane       <= 2'd0;
                end
                S_DATA: begin
                    lane <= lane + 2'd1;
                    unique case (lane)
                        2'd0: word_buf[7:0]   <= in_data;
                        2'd1: word_buf[15:8]  <= in_data;
                        2'd2: word_buf[23:16] <= in_data;
                        default: begin
                            mem_writedata <= {in_data, word_buf};
                            mem_address   <= wr_addr;
                            wr_addr       <= wr_addr + 16'd1;
                            words_left    <= words_left - 16'd1;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    // Running checksum over the frame body and the sticky error report.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum       <= '0;
            load_error <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            if (sync_hit) begin
                csum <= 8'h00;
            end else if (accept && state != S_IDLE) begin
                csum <= csum_final;
            end

            if (sync_hit) begin
                load_error <= 1'b0;
                err_code   <= ERR_NONE;
            end else if (csum_bad) begin
                load_error <= 1'b1;
                err_code   <= ERR_CHECKSUM;
            end else if (expired) begin
                load_error <= 1'b1;
                err_code   <= ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_loader.sv
// tb/tb_onchip_mem_loader.sv - self-checking bench for onchip_mem_loader
module tb_onchip_mem_loader;

    localparam int         TO   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        cpu_reset_req;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    onchip_mem_loader #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .cpu_reset_req  (cpu_reset_req),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .load_error     (load_error),
        .err_code       (err_code)
    );

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: position within the frame, counted in bytes after SYNC.
    int          m_pos = 0;
    int          m_cnt = 0;
    int          m_idle = 0;
    int          m_idx = 0;
    int          m_lane = 0;
    logic        m_acc = 1'b0;
    logic [15:0] m_base = '0;
    logic [7:0]  m_sum = '0;
    logic [31:0] m_word = '0;
    logic        e_ready = 1'b0;
    logic        e_wr = 1'b0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;
    logic [1:0]  e_code = '0;
    logic [15:0] e_addr = '0;
    logic [31:0] e_data = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos = 0; m_cnt = 0; m_idle = 0; m_base = '0; m_sum = '0; m_word = '0;
            e_ready = 0; e_wr = 0; e_done = 0; e_err = 0; e_code = '0; e_addr = '0; e_data = '0;
        end else begin
            m_acc  = in_valid && e_ready;
            e_wr   = 1'b0;
            e_done = 1'b0;
            if (m_acc) begin
                m_idle = 0;
                if (m_pos == 0) begin
                    if (in_data == SYNC) begin
                        m_pos = 1; m_sum = 8'h00; e_err = 1'b0; e_code = 2'b00;
                    end
                end else begin
                    m_sum = m_sum + in_data;
                    m_idx = m_pos;
                    if (m_idx == 1) m_base[15:8] = in_data;
                    else if (m_idx == 2) m_base[7:0] = in_data;
                    else if (m_idx == 3) m_cnt = int'(in_data) * 256;
                    else if (m_idx == 4) m_cnt = m_cnt + int'(in_data);
                    else if (m_idx < 5 + 4 * m_cnt) begin
                        m_lane = (m_idx - 5) % 4;
                        m_word[m_lane*8 +: 8] = in_data;
                        if (m_lane == 3) begin
                            e_wr   = 1'b1;
                            e_addr = m_base + 16'((m_idx - 5) / 4);
                            e_data = m_word;
                        end
                    end else begin
                        e_done = 1'b1;
                        if (m_sum != 8'h00) begin
                            e_err = 1'b1; e_code = 2'b01;
                        end
                        m_pos = 0;
                    end
                    if (m_pos != 0) m_pos++;
                end
            end else if (m_pos != 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_pos = 0; m_idle = 0; e_done = 1'b1; e_err = 1'b1; e_code = 2'b10;
                end
            end
            e_ready = 1'b1;
        end
    end

    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          done_cnt = 0;
    logic        c_busy;

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        c_busy = (m_pos != 0) || e_done;
        check("in_ready", in_ready, e_ready);
        check("mem_chipselect", mem_chipselect, e_wr);
        check("mem_write", mem_write, e_wr);
        check("mem_address", mem_address, e_addr);
        check("mem_writedata", mem_writedata, e_data);
        check("mem_byteenable", mem_byteenable, 4'hF);
        check("load_done", load_done, e_done);
        check("load_busy", load_busy, c_busy);
        check("cpu_reset_req", cpu_reset_req, c_busy);
        check("load_error", load_error, e_err);
        check("err_code", err_code, e_code);
        if (mem_write) begin
            wa_q.push_back(mem_address);
            wd_q.push_back(mem_writedata);
        end
        if (load_done) done_cnt++;
    end

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   guard;
        logic took;
        guard = 0;
        took  = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!took && guard < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!took) begin
            tests++;
            fails++;
            $display("FAIL send_byte actual=not_accepted required=accepted at %0t", $time);
        end
    endtask

    task automatic rand_gap(input int gmax);
        int r;
        if (gmax > 0) begin
            r = $urandom_range(0, 19);
            if (r == 0) idle_cycles(TO - 1);
            else if (r == 1 && gmax > 3) idle_cycles(TO);
            else idle_cycles($urandom_range(0, 2));
        end
    endtask

    task automatic send_frame(input logic [15:0] addr, input logic [7:0] data[$],
                              input bit corrupt, input int gmax);
        logic [15:0] cnt;
        logic [7:0]  s;
        logic [7:0]  cs;
        cnt = 16'(data.size() / 4);
        s = 8'h00;
        send_byte(SYNC); rand_gap(gmax);
        s += addr[15:8]; send_byte(addr[15:8]); rand_gap(gmax);
        s += addr[7:0];  send_byte(addr[7:0]);  rand_gap(gmax);
        s += cnt[15:8];  send_byte(cnt[15:8]);  rand_gap(gmax);
        s += cnt[7:0];   send_byte(cnt[7:0]);   rand_gap(gmax);
        foreach (data[i]) begin
            s += data[i];
            send_byte(data[i]);
            rand_gap(gmax);
        end
        cs = 8'h00 - s;
        if (corrupt) cs = cs ^ 8'h01;
        send_byte(cs);
    endtask

    logic [7:0] dq[$];
    int         d0;
    logic [7:0] g;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_busy", load_busy, 1'b0);
        check("reset_addr", mem_address, 16'h0000);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", in_ready, 1'b1);

        // Single word frame.
        wa_q.delete(); wd_q.delete(); d0 = done_cnt;
        dq = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(16'h0010, dq, 1'b0, 0);
        idle_cycles(2);
        check("t1_nwrites", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check("t1_addr", wa_q[0], 16'h0010);
            check("t1_data", wd_q[0], 32'h44332211);
        end
        check("t1_done", done_cnt - d0, 1);
        check("t1_err", load_error, 1'b0);

        // Address wrap.
        wa_q.delete(); wd_q.delete();
        dq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(16'hFFFF, dq, 1'b0, 0);
        idle_cycles(2);
        check("t2_nwrites", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check("t2_addr0", wa_q[0], 16'hFFFF);
            check("t2_addr1", wa_q[1], 16'h0000);
            check("t2_data1", wd_q[1], 32'h08070605);
        end

        // Bad checksum, then a SYNC clears the error.
        wa_q.delete(); wd_q.delete();
        dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(16'h0100, dq, 1'b1, 0);
        idle_cycles(2);
        check("t3_nwrites", wa_q.size(), 1);
        check("t3_err", load_error, 1'b1);
        check("t3_code", err_code, 2'b01);
        send_byte(SYNC);
        check("t3_err_clr", load_error, 1'b0);
        check("t3_code_clr", err_code, 2'b00);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'hE0);
        idle_cycles(2);
        check("t3_err_after", load_error, 1'b0);

        // Stall after ADDR_LO aborts; a gap one short of the limit does not.
        wa_q.delete(); d0 = done_cnt;
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h10);
        idle_cycles(TO + 4);
        check("t4_done", done_cnt - d0, 1);
        check("t4_err", load_error, 1'b1);
        check("t4_code", err_code, 2'b10);
        check("t4_cpu_reset", cpu_reset_req, 1'b0);
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h30);
        idle_cycles(TO - 1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'hD0);
        idle_cycles(2);
        check("t4_gap_err", load_error, 1'b0);
        check("t4_nwrites", wa_q.size(), 0);

        // Garbage then an empty frame.
        d0 = done_cnt;
        send_byte(8'h00); send_byte(8'hA4); send_byte(8'hFF);
        dq.delete();
        send_frame(16'h4321, dq, 1'b0, 0);
        idle_cycles(2);
        check("t5_nwrites", wa_q.size(), 0);
        check("t5_done", done_cnt - d0, 1);
        check("t5_err", load_error, 1'b0);

        // Reset in the middle of a data word.
        send_byte(SYNC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h66);
        reset_n = 1'b0;
        idle_cycles(2);
        check("t6_busy", load_busy, 1'b0);
        check("t6_ready", in_ready, 1'b0);
        check("t6_wdata", mem_writedata, 32'h0);
        reset_n = 1'b1;
        idle_cycles(3);
        check("t6_nwrites", wa_q.size(), 0);
        dq = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_frame(16'h0200, dq, 1'b0, 0);
        idle_cycles(2);
        check("t6_reload", wa_q.size(), 1);
        if (wa_q.size() == 1) check("t6_addr", wa_q[0], 16'h0200);

        // Randomized frames with gaps, garbage, corruption and occasional timeouts.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                send_byte(g);
            end
            dq.delete();
            for (int k = 0; k < 4 * int'($urandom_range(0, 3)); k++) dq.push_back(8'($urandom));
            send_frame(16'($urandom), dq, ($urandom_range(0, 3) == 0), $urandom_range(0, 5));
            idle_cycles($urandom_range(0, 3));
        end
        idle_cycles(TO + 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
